// File: rtl/multi_packet_scoreboard.sv
// multi_packet_scoreboard
// Tracks up to NUM_TRACK "magic" packets through a DUT FIFO of capacity DEPTH.
// Each slot remembers a captured data word and its distance from the FIFO head.
// When a slot reaches the head and is popped, it checks the DUT's data_out.
// Any mismatch raises a sticky err.
module multi_packet_scoreboard #(
   parameter int DEPTH     = 8,
   parameter int WIDTH     = 8,
   parameter int NUM_TRACK = 4,
   parameter int ONESHOT   = 0,
   parameter int CNTWID    = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             start,
   input  logic [WIDTH-1:0] data_in,
   input  logic [WIDTH-1:0] data_out,
   output logic             data_out_vld,
   output logic             prop_signal,
   output logic             err,
   output logic             en,
   output logic             track_full,
   output logic [15:0]      exit_cnt
);

   logic [CNTWID-1:0]    occ_q, occ_d;
   logic                 pushAcc, popAcc;
   logic [NUM_TRACK-1:0] valid_q, valid_d;
   logic [CNTWID-1:0]    pos_q  [NUM_TRACK];
   logic [CNTWID-1:0]    pos_d  [NUM_TRACK];
   logic [WIDTH-1:0]     data_q [NUM_TRACK];
   logic [WIDTH-1:0]     data_d [NUM_TRACK];
   logic                 capturedOnce_q, capturedOnce_d;
   logic                 err_q, err_d;
   logic [15:0]          exitCnt_q, exitCnt_d;
   logic [NUM_TRACK-1:0] exitHit, freeMask, capSel;
   logic [WIDTH-1:0]     exitData;
   logic                 capture, exitVld;
   logic [CNTWID-1:0]    capPos;

   // Mirror the DUT FIFO's accept rules so occupancy tracks what really entered.
   // Popping an empty FIFO is ignored. Pushing into a full FIFO is only accepted
   // when a pop makes room in the same cycle.
   always_comb begin
      popAcc  = pop & (occ_q != '0);
      pushAcc = push & ((occ_q < CNTWID'(DEPTH)) | popAcc);
      occ_d   = occ_q + CNTWID'(pushAcc) - CNTWID'(popAcc);
      capture = start & pushAcc & ~(&valid_q) & ~((ONESHOT != 0) & capturedOnce_q);
      capPos  = occ_q - CNTWID'(popAcc) + CNTWID'(1);
   end

   // Find the slot leaving the FIFO head this cycle, and pick the lowest-index slot for a capture.
   // A slot that is exiting in this cycle counts as free, so a capture can reuse it immediately.
   always_comb begin
      logic found;
      found    = 1'b0;
      exitData = '0;
      capSel   = '0;
      for (int i = 0; i < NUM_TRACK; i++) begin
         exitHit[i]  = valid_q[i] & popAcc & (pos_q[i] == CNTWID'(1));
         freeMask[i] = ~valid_q[i] | exitHit[i];
         if (exitHit[i]) begin
            exitData = exitData | data_q[i];
         end
         if (!found && freeMask[i]) begin
            capSel[i] = 1'b1;
            found     = 1'b1;
         end
      end
   end

   // Per-slot next state.
   // A capture wins over an exit in the same slot.
   // Surviving slots move one place closer to the head on each accepted pop.
   always_comb begin
      valid_d = valid_q;
      pos_d   = pos_q;
      data_d  = data_q;
      for (int i = 0; i < NUM_TRACK; i++) begin
         if (capture && capSel[i]) begin
            valid_d[i] = 1'b1;
            pos_d[i]   = capPos;
            data_d[i]  = data_in;
         end else if (exitHit[i]) begin
            valid_d[i] = 1'b0;
         end else if (valid_q[i] && popAcc && (pos_q[i] > CNTWID'(1))) begin
            pos_d[i] = pos_q[i] - CNTWID'(1);
         end
      end
   end

   // Exit reporting, the sticky error, and the saturating exit counter.
   // data_out_vld is masked while reset is asserted, so abandoned packets never report an exit.
   always_comb begin
      exitVld        = |exitHit;
      data_out_vld   = exitVld & ~rst;
      prop_signal    = ~data_out_vld | (exitData == data_out);
      err_d          = err_q | (exitVld & (exitData != data_out));
      exitCnt_d      = (exitVld && (exitCnt_q != 16'hFFFF)) ? exitCnt_q + 16'd1 : exitCnt_q;
      capturedOnce_d = capturedOnce_q | capture;
      en             = |valid_q;
      track_full     = &valid_q;
      err            = err_q;
      exit_cnt       = exitCnt_q;
   end

   // Control state: reset clears occupancy, all slot valids and the status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         occ_q          <= '0;
         valid_q        <= '0;
         capturedOnce_q <= 1'b0;
         err_q          <= 1'b0;
         exitCnt_q      <= '0;
      end else begin
         occ_q          <= occ_d;
         valid_q        <= valid_d;
         capturedOnce_q <= capturedOnce_d;
         err_q          <= err_d;
         exitCnt_q      <= exitCnt_d;
      end
   end

   // Slot payload: meaningless while its valid is low, so it needs no reset.
   always_ff @(posedge clk) begin
      pos_q  <= pos_d;
      data_q <= data_d;
   end

endmodule

// File: tb/tb_multi_packet_scoreboard.sv
// tb_multi_packet_scoreboard
// Two instances are used.
// Instance A has default parameters and covers multi-slot tracking.
// Instance B has ONESHOT=1 and NUM_TRACK=1 and covers legacy single-packet mode.
// Expected exits are queued by the stimulus; monitors pop them whenever data_out_vld rises.
module tb_multi_packet_scoreboard;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rstA = 1'b1, pushA = 1'b0, popA = 1'b0, startA = 1'b0;
   logic [7:0] dinA = '0, doutA = '0;
   logic       vldA, propA, errA, enA, fullA;
   logic [15:0] cntA;

   logic       rstB = 1'b1, pushB = 1'b0, popB = 1'b0, startB = 1'b0;
   logic [7:0] dinB = '0, doutB = '0;
   logic       vldB, propB, errB, enB, fullB;
   logic [15:0] cntB;

   int compared   = 0;
   int mismatched = 0;

   // Each entry is {expected prop_signal, expected exit_cnt seen during the exit cycle}.
   logic [16:0] expA[$];
   logic [16:0] expB[$];

   multi_packet_scoreboard dutA (
      .clk(clk), .rst(rstA), .push(pushA), .pop(popA), .start(startA),
      .data_in(dinA), .data_out(doutA), .data_out_vld(vldA), .prop_signal(propA),
      .err(errA), .en(enA), .track_full(fullA), .exit_cnt(cntA)
   );

   multi_packet_scoreboard #(.NUM_TRACK(1), .ONESHOT(1)) dutB (
      .clk(clk), .rst(rstB), .push(pushB), .pop(popB), .start(startB),
      .data_in(dinB), .data_out(doutB), .data_out_vld(vldB), .prop_signal(propB),
      .err(errB), .en(enB), .track_full(fullB), .exit_cnt(cntB)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs to the selected instance, then settle just past the edge.
   task automatic applyStimulus(input bit selB, input logic ps, input logic pp, input logic st,
                                input logic [7:0] din, input logic [7:0] dout);
      if (selB) begin
         pushB = ps; popB = pp; startB = st; dinB = din; doutB = dout;
      end else begin
         pushA = ps; popA = pp; startA = st; dinA = din; doutA = dout;
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor for instance A: every exit must match the head of the expected queue.
   always @(negedge clk) begin
      if (vldA === 1'b1) begin
         if (expA.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL A unexpected exit: got vld 1, expected 0 at %0t", $time);
         end else begin
            logic [16:0] e;
            e = expA.pop_front();
            checkOutput("A exit prop_signal", {31'd0, propA}, {31'd0, e[16]});
            checkOutput("A exit exit_cnt", {16'd0, cntA}, {16'd0, e[15:0]});
         end
      end else if (!rstA) begin
         checkOutput("A idle prop_signal", {31'd0, propA}, 32'd1);
      end
   end

   // Monitor for instance B: same rules as A.
   always @(negedge clk) begin
      if (vldB === 1'b1) begin
         if (expB.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL B unexpected exit: got vld 1, expected 0 at %0t", $time);
         end else begin
            logic [16:0] e;
            e = expB.pop_front();
            checkOutput("B exit prop_signal", {31'd0, propB}, {31'd0, e[16]});
            checkOutput("B exit exit_cnt", {16'd0, cntB}, {16'd0, e[15:0]});
         end
      end
   end

   // Watchdog so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Reset both instances and check the reset-time outputs.
      @(posedge clk);
      #1;
      checkOutput("A rst data_out_vld", {31'd0, vldA}, 32'd0);
      checkOutput("A rst prop_signal", {31'd0, propA}, 32'd1);
      checkOutput("A rst en", {31'd0, enA}, 32'd0);
      checkOutput("A rst track_full", {31'd0, fullA}, 32'd0);
      checkOutput("A rst err", {31'd0, errA}, 32'd0);
      checkOutput("A rst exit_cnt", {16'd0, cntA}, 32'd0);
      checkOutput("B rst en", {31'd0, enB}, 32'd0);
      @(posedge clk);
      #1;
      rstA = 1'b0;
      rstB = 1'b0;

      // Single packet: capture at occupancy 0, then exit on the next pop.
      applyStimulus(0, 1, 0, 1, 8'h11, 8'h00);
      checkOutput("A t1 en while tracking", {31'd0, enA}, 32'd1);
      expA.push_back({1'b1, 16'd0});
      applyStimulus(0, 0, 1, 0, 8'h00, 8'h11);
      checkOutput("A t1 exit_cnt", {16'd0, cntA}, 32'd1);
      checkOutput("A t1 en after exit", {31'd0, enA}, 32'd0);

      // Middle packet of three: only the second pop reports an exit.
      applyStimulus(0, 1, 0, 0, 8'h21, 8'h00);
      applyStimulus(0, 1, 0, 1, 8'h22, 8'h00);
      applyStimulus(0, 1, 0, 0, 8'h23, 8'h00);
      applyStimulus(0, 0, 1, 0, 8'h00, 8'h21);
      expA.push_back({1'b1, 16'd1});
      applyStimulus(0, 0, 1, 0, 8'h00, 8'h22);
      applyStimulus(0, 0, 1, 0, 8'h00, 8'h23);
      checkOutput("A t2 err", {31'd0, errA}, 32'd0);
      checkOutput("A t2 exit_cnt", {16'd0, cntA}, 32'd2);

      // Five starts into four slots: the fifth is dropped, four exits in order.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, 1, 0, 1, 8'h31 + 8'(i), 8'h00);
         if (i == 3) checkOutput("A t3 track_full after 4", {31'd0, fullA}, 32'd1);
      end
      checkOutput("A t3 track_full after 5", {31'd0, fullA}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         if (i < 4) expA.push_back({1'b1, 16'(2 + i)});
         applyStimulus(0, 0, 1, 0, 8'h00, 8'h31 + 8'(i));
      end
      checkOutput("A t3 exit_cnt", {16'd0, cntA}, 32'd6);
      checkOutput("A t3 track_full drained", {31'd0, fullA}, 32'd0);
      checkOutput("A t3 en drained", {31'd0, enA}, 32'd0);

      // Capture with a simultaneous pop at occupancy 3: the packet exits on the third pop after.
      applyStimulus(0, 1, 0, 0, 8'h41, 8'h00);
      applyStimulus(0, 1, 0, 0, 8'h42, 8'h00);
      applyStimulus(0, 1, 0, 0, 8'h43, 8'h00);
      applyStimulus(0, 1, 1, 1, 8'h44, 8'h41);
      applyStimulus(0, 0, 1, 0, 8'h00, 8'h42);
      applyStimulus(0, 0, 1, 0, 8'h00, 8'h43);
      checkOutput("A t5 en before exit", {31'd0, enA}, 32'd1);
      expA.push_back({1'b1, 16'd6});
      applyStimulus(0, 0, 1, 0, 8'h00, 8'h44);
      checkOutput("A t5 exit_cnt", {16'd0, cntA}, 32'd7);

      // Mismatching exit: prop_signal low that cycle, err set afterwards and sticky.
      applyStimulus(0, 1, 0, 1, 8'h5A, 8'h00);
      expA.push_back({1'b0, 16'd7});
      applyStimulus(0, 0, 1, 0, 8'h00, 8'h5B);
      checkOutput("A t4 err set", {31'd0, errA}, 32'd1);
      applyStimulus(0, 0, 0, 0, 8'h00, 8'h00);
      applyStimulus(0, 0, 0, 0, 8'h00, 8'h00);
      checkOutput("A t4 err sticky", {31'd0, errA}, 32'd1);
      checkOutput("A t4 exit_cnt", {16'd0, cntA}, 32'd8);

      // Push and pop on an empty FIFO act as a push only; there is no bypass exit.
      applyStimulus(0, 1, 1, 1, 8'h61, 8'h00);
      checkOutput("A t6 en after push-only", {31'd0, enA}, 32'd1);
      expA.push_back({1'b1, 16'd8});
      applyStimulus(0, 0, 1, 0, 8'h00, 8'h61);
      checkOutput("A t6 exit_cnt", {16'd0, cntA}, 32'd9);

      // One-shot mode: after the first capture, later starts are ignored.
      applyStimulus(1, 1, 0, 1, 8'h71, 8'h00);
      checkOutput("B first capture en", {31'd0, enB}, 32'd1);
      expB.push_back({1'b1, 16'd0});
      applyStimulus(1, 0, 1, 0, 8'h00, 8'h71);
      checkOutput("B exit_cnt after first", {16'd0, cntB}, 32'd1);
      applyStimulus(1, 1, 0, 1, 8'h72, 8'h00);
      checkOutput("B second start ignored", {31'd0, enB}, 32'd0);
      applyStimulus(1, 0, 1, 0, 8'h00, 8'h72);
      checkOutput("B exit_cnt unchanged", {16'd0, cntB}, 32'd1);

      // Reset while a packet is in flight abandons it without reporting an exit.
      rstB = 1'b1;
      applyStimulus(1, 0, 0, 0, 8'h00, 8'h00);
      rstB = 1'b0;
      applyStimulus(1, 1, 0, 1, 8'h73, 8'h00);
      checkOutput("B recapture after reset", {31'd0, enB}, 32'd1);
      applyStimulus(1, 1, 0, 0, 8'h74, 8'h00);
      rstB = 1'b1;
      applyStimulus(1, 0, 0, 0, 8'h00, 8'h00);
      rstB = 1'b0;
      checkOutput("B mid-flight reset en", {31'd0, enB}, 32'd0);
      checkOutput("B mid-flight reset exit_cnt", {16'd0, cntB}, 32'd0);
      applyStimulus(1, 1, 0, 0, 8'h75, 8'h00);
      applyStimulus(1, 0, 1, 0, 8'h00, 8'h73);
      applyStimulus(1, 0, 1, 0, 8'h00, 8'h74);
      applyStimulus(1, 0, 0, 0, 8'h00, 8'h00);
      checkOutput("B exit_cnt after reset pops", {16'd0, cntB}, 32'd0);

      // Every queued exit must have been observed.
      checkOutput("A expected exits remaining", expA.size(), 32'd0);
      checkOutput("B expected exits remaining", expB.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
